key_event_decoder: RTL and testbench

Consumes the debounced key interface (a one-cycle key_flag pulse plus a key_state level: 1 = released, 0 = pressed). Classifies each gesture as a short press, a long press with auto-repeat, or a double click, and emits one-cycle event pulses. Sits between the key debounce filter and application logic such as menu or counter control.

---
 rtl/key_event_decoder.sv | 82 ++++++++
 tb/tb_key_event_decoder.sv | 85 ++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies debounced key gestures into short, long, repeat and double-click pulses
module key_event_decoder #(
  parameter int LONG_CNT = 24000000,
  parameter int DBL_CNT  = 7200000,
  parameter int REP_CNT  = 4800000,
  parameter int CNT_W    = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic key_flag,
  input  logic key_state,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic double_click,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_short, r_long, r_rep, r_dbl;
  logic w_short, w_long, w_rep, w_dbl;
  logic w_press, w_rel, w_long_hit, w_dbl_hit, w_rep_hit, w_cnt_clr, w_cnt_run;
  assign w_press    = key_flag & ~key_state;
  assign w_rel      = key_flag & key_state;
  assign w_long_hit = r_cnt == CNT_W'(LONG_CNT - 1);
  assign w_dbl_hit  = r_cnt == CNT_W'(DBL_CNT - 1);
  assign w_rep_hit  = r_cnt == CNT_W'(REP_CNT - 1);
  // next state and event decode; releases and presses win over coincident timeouts
  always_comb begin
    w_next  = r_state;
    w_short = 1'b0;
    w_long  = 1'b0;
    w_rep   = 1'b0;
    w_dbl   = 1'b0;
    case (r_state)
      IDLE:    w_next = w_press ? PRESS1 : IDLE;
      PRESS1: begin
        w_next = w_rel ? WAIT2 : w_long_hit ? LONG : PRESS1;
        w_long = ~w_rel & w_long_hit;
      end
      WAIT2: begin
        w_next  = w_press ? PRESS2 : w_dbl_hit ? IDLE : WAIT2;
        w_short = ~w_press & w_dbl_hit;
      end
      PRESS2: begin
        w_next = w_rel ? IDLE : PRESS2;
        w_dbl  = w_rel;
      end
      LONG: begin
        w_next = w_rel ? IDLE : LONG;
        w_rep  = ~w_rel & w_rep_hit;
      end
      default: w_next = IDLE;
    endcase
  end
  assign w_cnt_clr = (w_next != r_state) | w_rep;
  assign w_cnt_run = (r_state == PRESS1) | (r_state == WAIT2) | (r_state == LONG);
  // state, shared gesture counter and registered event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      r_rep   <= 1'b0;
      r_dbl   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_cnt_clr | ~w_cnt_run) ? '0 : r_cnt + 1'b1;
      r_short <= w_short;
      r_long  <= w_long;
      r_rep   <= w_rep;
      r_dbl   <= w_dbl;
    end
  end
  assign short_press  = r_short;
  assign long_press   = r_long;
  assign repeat_pulse = r_rep;
  assign double_click = r_dbl;
  assign busy         = r_state != IDLE;
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed gesture scenarios with hand-computed pulse cycles
module tb_key_event_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_flag = 1'b0;
  logic key_state = 1'b1;
  logic short_press, long_press, repeat_pulse, double_click, busy;
  int checks = 0;
  int errors = 0;
  int q_press[$], q_rel[$], q_short[$], q_long[$], q_rep[$], q_dbl[$];
  int b0, b1;
  key_event_decoder #(.LONG_CNT(20), .DBL_CNT(10), .REP_CNT(5), .CNT_W(25)) dut (
    .clk(clk), .rst(rst), .key_flag(key_flag), .key_state(key_state),
    .short_press(short_press), .long_press(long_press), .repeat_pulse(repeat_pulse),
    .double_click(double_click), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask
  function automatic logic in_q(input int q[$], input int c);
    foreach (q[i]) if (q[i] == c) return 1'b1;
    return 1'b0;
  endfunction
  task automatic clr();
    q_press.delete(); q_rel.delete(); q_short.delete();
    q_long.delete(); q_rep.delete(); q_dbl.delete();
    b0 = -1; b1 = -1;
  endtask
  task automatic do_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      key_flag = i[0];
      key_state = 1'b0;
      @(negedge clk);
      if (i > 0) chk($sformatf("%s_rst%0d", tag, i),
                     {short_press, long_press, repeat_pulse, double_click} | {3'b0, busy}, 4'b0);
    end
  endtask
  task automatic run(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      key_flag = in_q(q_press, c) | in_q(q_rel, c);
      key_state = in_q(q_rel, c);
      @(negedge clk);
      chk($sformatf("%s_ev_c%0d", tag, c), {short_press, long_press, repeat_pulse, double_click},
          {in_q(q_short, c), in_q(q_long, c), in_q(q_rep, c), in_q(q_dbl, c)});
      chk($sformatf("%s_busy_c%0d", tag, c), {3'b0, busy}, {3'b0, (c >= b0 && c < b1)});
    end
  endtask
  initial begin
    clr();
    do_reset("init");
    clr(); q_press = '{0}; q_rel = '{8}; q_short = '{19}; b0 = 1; b1 = 19;
    run("short", 25);
    do_reset("r2");
    clr(); q_press = '{0}; q_rel = '{40}; q_long = '{21}; q_rep = '{26, 31, 36}; b0 = 1; b1 = 41;
    run("long", 45);
    do_reset("r3");
    clr(); q_press = '{0, 12}; q_rel = '{5, 60}; q_dbl = '{61}; b0 = 1; b1 = 61;
    run("dbl", 65);
    do_reset("r4");
    clr(); q_press = '{0}; q_rel = '{20}; q_short = '{31}; b0 = 1; b1 = 31;
    run("race_long", 36);
    do_reset("r5");
    clr(); q_press = '{0, 18}; q_rel = '{8, 22}; q_dbl = '{23}; b0 = 1; b1 = 23;
    run("race_dbl", 28);
    do_reset("r6");
    clr(); q_press = '{0}; q_long = '{21}; q_rep = '{26}; b0 = 1; b1 = 30;
    run("mid_long", 30);
    do_reset("mid_rst");
    clr();
    run("after_rst", 15);
    clr(); q_press = '{2, 10}; q_rel = '{0, 12}; q_short = '{23}; b0 = 3; b1 = 23;
    run("stray", 28);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
